pipe_trace_monitor: RTL and testbench

- Synthesizable observer that sits directly downstream of the 5-stage pipeline top.
- Consumes the top's fetch PC, stall and flush outputs plus the register-file write-back port.
- Maintains a hardware shadow pipeline of PCs and valid bits for IF/ID/EX/MEM/WB, and keeps saturating performance counters.
- Raises a done flag when a programmed register write is seen, or a timeout flag when a cycle limit is reached. After either flag it freezes, so a bench or debug port can read final state.

---
 rtl/pipe_trace_monitor.sv | 155 +++++++++++++++
 tb/tb_pipe_trace_monitor.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_trace_monitor.sv
// rtl/pipe_trace_monitor.sv - shadow pipeline tracker with saturating counters and done/timeout freeze
module pipe_trace_monitor #(
    parameter int CNT_W      = 32,
    parameter int DONE_REG   = 9,
    parameter int DONE_VALUE = 200,
    parameter int TIMEOUT    = 50
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [31:0]      pc_in,
    input  logic             stall_in,
    input  logic             flush_in,
    input  logic             wb_we,
    input  logic [4:0]       wb_rd,
    input  logic [31:0]      wb_data,
    output logic [31:0]      pc_if,
    output logic [31:0]      pc_id,
    output logic [31:0]      pc_ex,
    output logic [31:0]      pc_mem,
    output logic [31:0]      pc_wb,
    output logic [4:0]       valid_vec,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] done_cycles
);

    logic [31:0]      pc_if_q, pc_if_d, pc_id_q, pc_id_d, pc_ex_q, pc_ex_d;
    logic [31:0]      pc_mem_q, pc_mem_d, pc_wb_q, pc_wb_d;
    logic [4:0]       valid_q, valid_d;
    logic [CNT_W-1:0] cycle_q, cycle_d, retired_q, retired_d;
    logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
    logic [CNT_W-1:0] done_cycles_q, done_cycles_d;
    logic             done_q, done_d, timeout_q, timeout_d;
    logic             frozen, hit_done;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    assign frozen   = done_q | timeout_q;
    // Register 0 is hardwired zero, so a write to it can never mean completion
    assign hit_done = wb_we && (wb_rd != 5'd0) && (wb_rd == 5'(DONE_REG))
                      && (wb_data == 32'(DONE_VALUE));

    always_comb begin
        pc_if_d       = pc_if_q;
        pc_id_d       = pc_id_q;
        pc_ex_d       = pc_ex_q;
        pc_mem_d      = pc_mem_q;
        pc_wb_d       = pc_wb_q;
        valid_d       = valid_q;
        cycle_d       = cycle_q;
        retired_d     = retired_q;
        stall_d       = stall_q;
        flush_d       = flush_q;
        done_d        = done_q;
        timeout_d     = timeout_q;
        done_cycles_d = done_cycles_q;
        if (clr) begin
            pc_if_d       = '0;
            pc_id_d       = '0;
            pc_ex_d       = '0;
            pc_mem_d      = '0;
            pc_wb_d       = '0;
            valid_d       = '0;
            cycle_d       = '0;
            retired_d     = '0;
            stall_d       = '0;
            flush_d       = '0;
            done_d        = 1'b0;
            timeout_d     = 1'b0;
            done_cycles_d = '0;
        end else if (!frozen) begin
            pc_if_d    = pc_in;
            valid_d[0] = 1'b1;
            if (flush_in) begin
                pc_id_d    = pc_if_q;
                valid_d[1] = 1'b0;
            end else if (!stall_in) begin
                pc_id_d    = pc_if_q;
                valid_d[1] = valid_q[0];
            end
            pc_ex_d    = pc_id_q;
            valid_d[2] = valid_q[1] & ~stall_in & ~flush_in;
            pc_mem_d   = pc_ex_q;
            valid_d[3] = valid_q[2];
            pc_wb_d    = pc_mem_q;
            valid_d[4] = valid_q[3];

            cycle_d   = sat_inc(cycle_q, 1'b1);
            retired_d = sat_inc(retired_q, valid_q[4]);
            stall_d   = sat_inc(stall_q, stall_in);
            flush_d   = sat_inc(flush_q, flush_in);

            if (hit_done) begin
                done_d        = 1'b1;
                done_cycles_d = cycle_d;
            end
            if ((TIMEOUT != 0) && (cycle_d == CNT_W'(TIMEOUT)))
                timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_if_q       <= '0;
            pc_id_q       <= '0;
            pc_ex_q       <= '0;
            pc_mem_q      <= '0;
            pc_wb_q       <= '0;
            valid_q       <= '0;
            cycle_q       <= '0;
            retired_q     <= '0;
            stall_q       <= '0;
            flush_q       <= '0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
            done_cycles_q <= '0;
        end else begin
            pc_if_q       <= pc_if_d;
            pc_id_q       <= pc_id_d;
            pc_ex_q       <= pc_ex_d;
            pc_mem_q      <= pc_mem_d;
            pc_wb_q       <= pc_wb_d;
            valid_q       <= valid_d;
            cycle_q       <= cycle_d;
            retired_q     <= retired_d;
            stall_q       <= stall_d;
            flush_q       <= flush_d;
            done_q        <= done_d;
            timeout_q     <= timeout_d;
            done_cycles_q <= done_cycles_d;
        end
    end

    assign pc_if       = pc_if_q;
    assign pc_id       = pc_id_q;
    assign pc_ex       = pc_ex_q;
    assign pc_mem      = pc_mem_q;
    assign pc_wb       = pc_wb_q;
    assign valid_vec   = valid_q;
    assign cycle_cnt   = cycle_q;
    assign retired_cnt = retired_q;
    assign stall_cnt   = stall_q;
    assign flush_cnt   = flush_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign done_cycles = done_cycles_q;

endmodule

// File: tb/tb_pipe_trace_monitor.sv
// tb/tb_pipe_trace_monitor.sv - directed vector bench for pipe_trace_monitor
module tb_pipe_trace_monitor;

    logic        clk = 1'b0;
    logic        reset, clr, stall_in, flush_in, wb_we;
    logic [31:0] pc_in, wb_data;
    logic [4:0]  wb_rd;

    logic [31:0] pc_if, pc_id, pc_ex, pc_mem, pc_wb;
    logic [4:0]  valid_vec;
    logic [31:0] cycle_cnt, retired_cnt, stall_cnt, flush_cnt, done_cycles;
    logic        done, timeout;

    logic [31:0] s_pc_if, s_pc_id, s_pc_ex, s_pc_mem, s_pc_wb;
    logic [4:0]  s_valid;
    logic [2:0]  s_cycle, s_retired, s_stall, s_flush, s_done_cycles;
    logic        s_done, s_timeout;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_trace_monitor dut (
        .clk(clk), .reset(reset), .clr(clr), .pc_in(pc_in), .stall_in(stall_in),
        .flush_in(flush_in), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .pc_if(pc_if), .pc_id(pc_id), .pc_ex(pc_ex), .pc_mem(pc_mem), .pc_wb(pc_wb),
        .valid_vec(valid_vec), .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .done(done), .timeout(timeout),
        .done_cycles(done_cycles)
    );

    // Narrow counters with timeout disabled: exercises saturation and TIMEOUT=0
    pipe_trace_monitor #(.CNT_W(3), .TIMEOUT(0)) dut_sat (
        .clk(clk), .reset(reset), .clr(clr), .pc_in(pc_in), .stall_in(stall_in),
        .flush_in(flush_in), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .pc_if(s_pc_if), .pc_id(s_pc_id), .pc_ex(s_pc_ex), .pc_mem(s_pc_mem), .pc_wb(s_pc_wb),
        .valid_vec(s_valid), .cycle_cnt(s_cycle), .retired_cnt(s_retired),
        .stall_cnt(s_stall), .flush_cnt(s_flush), .done(s_done), .timeout(s_timeout),
        .done_cycles(s_done_cycles)
    );

    typedef struct {
        logic [31:0] pc;
        logic        stall, flush, we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] e_if, e_id, e_ex, e_mem, e_wb;
        logic [4:0]  e_v;
        int          e_cyc, e_ret, e_stl, e_fl;
        logic        e_done;
        int          e_dcyc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int pc, input int s, input int f, input int we, input int rd,
                       input int data, input int ei, input int ed, input int ee, input int em,
                       input int ew, input logic [4:0] ev, input int cyc, input int ret,
                       input int stl, input int fl, input int dn, input int dcyc);
        vec_t v;
        v.pc = 32'(pc); v.stall = s[0]; v.flush = f[0]; v.we = we[0]; v.rd = 5'(rd);
        v.data = 32'(data); v.e_if = 32'(ei); v.e_id = 32'(ed); v.e_ex = 32'(ee);
        v.e_mem = 32'(em); v.e_wb = 32'(ew); v.e_v = ev; v.e_cyc = cyc; v.e_ret = ret;
        v.e_stl = stl; v.e_fl = fl; v.e_done = dn[0]; v.e_dcyc = dcyc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sat7(input int v);
        return (v > 7) ? 32'd7 : 32'(v);
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        stall_in = 1'b0; flush_in = 1'b0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    endtask

    initial begin
        int n;
        reset = 1'b1; clr = 1'b0; pc_in = 32'd0;
        idle_inputs();

        //   pc  s f we rd data | if  id  ex  mem wb  valid     cyc ret stl fl dn dcyc
        add( 0, 0,0,0,0,  0,     0,  0,  0,  0,  0, 5'b00001,  1,  0, 0, 0, 0, 0);
        add( 4, 0,0,0,0,  0,     4,  0,  0,  0,  0, 5'b00011,  2,  0, 0, 0, 0, 0);
        add( 8, 0,0,0,0,  0,     8,  4,  0,  0,  0, 5'b00111,  3,  0, 0, 0, 0, 0);
        add(12, 0,0,0,0,  0,    12,  8,  4,  0,  0, 5'b01111,  4,  0, 0, 0, 0, 0);
        add(16, 0,0,0,0,  0,    16, 12,  8,  4,  0, 5'b11111,  5,  0, 0, 0, 0, 0);
        add(20, 0,0,0,0,  0,    20, 16, 12,  8,  4, 5'b11111,  6,  1, 0, 0, 0, 0);
        add(24, 1,0,0,0,  0,    24, 16, 16, 12,  8, 5'b11011,  7,  2, 1, 0, 0, 0);
        add(28, 0,0,0,0,  0,    28, 24, 16, 16, 12, 5'b10111,  8,  3, 1, 0, 0, 0);
        add(32, 0,0,0,0,  0,    32, 28, 24, 16, 16, 5'b01111,  9,  4, 1, 0, 0, 0);
        add(36, 0,0,0,0,  0,    36, 32, 28, 24, 16, 5'b11111, 10,  4, 1, 0, 0, 0);
        add(40, 1,1,0,0,  0,    40, 36, 32, 28, 24, 5'b11001, 11,  5, 2, 1, 0, 0);
        add(44, 0,0,0,0,  0,    44, 40, 36, 32, 28, 5'b10011, 12,  6, 2, 1, 0, 0);
        add(48, 0,1,0,0,  0,    48, 44, 40, 36, 32, 5'b00001, 13,  7, 2, 2, 0, 0);
        add(52, 0,0,0,0,  0,    52, 48, 44, 40, 36, 5'b00011, 14,  7, 2, 2, 0, 0);
        add(56, 0,0,0,0,  0,    56, 52, 48, 44, 40, 5'b00111, 15,  7, 2, 2, 0, 0);
        add(60, 0,0,1,9,199,    60, 56, 52, 48, 44, 5'b01111, 16,  7, 2, 2, 0, 0);
        add(64, 0,0,1,0,200,    64, 60, 56, 52, 48, 5'b11111, 17,  7, 2, 2, 0, 0);
        add(68, 0,0,0,9,200,    68, 64, 60, 56, 52, 5'b11111, 18,  8, 2, 2, 0, 0);
        add(72, 0,0,0,0,  0,    72, 68, 64, 60, 56, 5'b11111, 19,  9, 2, 2, 0, 0);
        add(76, 0,0,1,9,200,    76, 72, 68, 64, 60, 5'b11111, 20, 10, 2, 2, 1, 20);
        add(80, 1,1,1,9,200,    76, 72, 68, 64, 60, 5'b11111, 20, 10, 2, 2, 1, 20);
        add(84, 0,0,0,0,  0,    76, 72, 68, 64, 60, 5'b11111, 20, 10, 2, 2, 1, 20);

        step();
        chk("reset_pc_if", pc_if, 32'd0);
        chk("reset_valid", {27'd0, valid_vec}, 32'd0);
        chk("reset_cycle", cycle_cnt, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            pc_in = vecs[i].pc; stall_in = vecs[i].stall; flush_in = vecs[i].flush;
            wb_we = vecs[i].we; wb_rd = vecs[i].rd; wb_data = vecs[i].data;
            step();
            chk($sformatf("r%0d_pc_if", i), pc_if, vecs[i].e_if);
            chk($sformatf("r%0d_pc_id", i), pc_id, vecs[i].e_id);
            chk($sformatf("r%0d_pc_ex", i), pc_ex, vecs[i].e_ex);
            chk($sformatf("r%0d_pc_mem", i), pc_mem, vecs[i].e_mem);
            chk($sformatf("r%0d_pc_wb", i), pc_wb, vecs[i].e_wb);
            chk($sformatf("r%0d_valid", i), {27'd0, valid_vec}, {27'd0, vecs[i].e_v});
            chk($sformatf("r%0d_cycle", i), cycle_cnt, 32'(vecs[i].e_cyc));
            chk($sformatf("r%0d_retired", i), retired_cnt, 32'(vecs[i].e_ret));
            chk($sformatf("r%0d_stall", i), stall_cnt, 32'(vecs[i].e_stl));
            chk($sformatf("r%0d_flush", i), flush_cnt, 32'(vecs[i].e_fl));
            chk($sformatf("r%0d_done", i), {31'd0, done}, {31'd0, vecs[i].e_done});
            chk($sformatf("r%0d_timeout", i), {31'd0, timeout}, 32'd0);
            chk($sformatf("r%0d_done_cycles", i), done_cycles, 32'(vecs[i].e_dcyc));
            chk($sformatf("r%0d_s_pc_if", i), s_pc_if, vecs[i].e_if);
            chk($sformatf("r%0d_s_pc_id", i), s_pc_id, vecs[i].e_id);
            chk($sformatf("r%0d_s_pc_ex", i), s_pc_ex, vecs[i].e_ex);
            chk($sformatf("r%0d_s_pc_mem", i), s_pc_mem, vecs[i].e_mem);
            chk($sformatf("r%0d_s_pc_wb", i), s_pc_wb, vecs[i].e_wb);
            chk($sformatf("r%0d_s_valid", i), {27'd0, s_valid}, {27'd0, vecs[i].e_v});
            chk($sformatf("r%0d_s_cycle", i), {29'd0, s_cycle}, sat7(vecs[i].e_cyc));
            chk($sformatf("r%0d_s_retired", i), {29'd0, s_retired}, sat7(vecs[i].e_ret));
            chk($sformatf("r%0d_s_stall", i), {29'd0, s_stall}, sat7(vecs[i].e_stl));
            chk($sformatf("r%0d_s_flush", i), {29'd0, s_flush}, sat7(vecs[i].e_fl));
            chk($sformatf("r%0d_s_done", i), {31'd0, s_done}, {31'd0, vecs[i].e_done});
            chk($sformatf("r%0d_s_timeout", i), {31'd0, s_timeout}, 32'd0);
            chk($sformatf("r%0d_s_done_cycles", i), {29'd0, s_done_cycles}, sat7(vecs[i].e_dcyc));
        end
        idle_inputs();

        clr = 1'b1; pc_in = 32'h55;
        step();
        clr = 1'b0;
        chk("clr_pc_if", pc_if, 32'd0);
        chk("clr_pc_wb", pc_wb, 32'd0);
        chk("clr_valid", {27'd0, valid_vec}, 32'd0);
        chk("clr_cycle", cycle_cnt, 32'd0);
        chk("clr_retired", retired_cnt, 32'd0);
        chk("clr_stall", stall_cnt, 32'd0);
        chk("clr_flush", flush_cnt, 32'd0);
        chk("clr_done", {31'd0, done}, 32'd0);
        chk("clr_done_cycles", done_cycles, 32'd0);
        chk("clr_s_done", {31'd0, s_done}, 32'd0);

        n = 0;
        for (int i = 1; i <= 60; i++) begin
            pc_in = 32'(4 * i);
            step();
            n = i;
            if (timeout) break;
        end
        chk("to_steps", 32'(n), 32'd50);
        chk("to_cycle", cycle_cnt, 32'd50);
        chk("to_retired", retired_cnt, 32'd45);
        chk("to_pc_if", pc_if, 32'd200);
        chk("to_done", {31'd0, done}, 32'd0);
        pc_in = 32'd999;
        step();
        step();
        chk("to_hold_flag", {31'd0, timeout}, 32'd1);
        chk("to_hold_cycle", cycle_cnt, 32'd50);
        chk("to_hold_pc_if", pc_if, 32'd200);
        chk("to_s_no_timeout", {31'd0, s_timeout}, 32'd0);
        chk("to_s_cycle_sat", {29'd0, s_cycle}, 32'd7);
        chk("to_s_pc_if", s_pc_if, 32'd999);

        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr2_timeout", {31'd0, timeout}, 32'd0);
        chk("clr2_cycle", cycle_cnt, 32'd0);
        for (int i = 0; i < 3; i++) begin
            pc_in = 32'(8 + 4 * i);
            step();
        end
        chk("pre_rst_cycle", cycle_cnt, 32'd3);
        chk("pre_rst_pc_if", pc_if, 32'd16);

        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_pc_if", pc_if, 32'd0);
        chk("async_pc_id", pc_id, 32'd0);
        chk("async_valid", {27'd0, valid_vec}, 32'd0);
        chk("async_cycle", cycle_cnt, 32'd0);
        chk("async_s_cycle", {29'd0, s_cycle}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        pc_in = 32'd100;
        step();
        chk("post_rst_pc_if", pc_if, 32'd100);
        chk("post_rst_valid", {27'd0, valid_vec}, 32'd1);
        chk("post_rst_cycle", cycle_cnt, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
